data_mem_arb: RTL and testbench

Parametrised single-port data memory for the frame buffer path. It accepts independent write and read request channels and arbitrates them round-robin when both are pending. It applies per-byte write enables and returns read data through a configurable-latency pipeline with a valid strobe. An optional repeat-suppression mode, programmable depth with out-of-range detection, and explicit ready handshakes extend the older two-state read/write memory model.

---
 rtl/data_mem_arb.sv | 154 +++++++++++++++
 tb/tb_data_mem_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arb
// Description : Single-port data memory. Write and read request channels are
//               arbitrated round-robin. Writes use per-byte enables. Reads
//               return through a configurable-latency pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY  = 1,
  parameter int SKIP_REPEAT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    wr_ready,
  output logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_data_valid,
  output logic                    addr_err
);

  localparam int                  c_NBYTES  = DATA_WIDTH / 8;
  localparam int                  c_IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [0:0]          c_GNT_WR  = 1'b0;
  localparam logic [0:0]          c_GNT_RD  = 1'b1;
  localparam bit                  c_SKIP_EN = (SKIP_REPEAT != 0);

  logic [0:0]            r_last_grant;
  logic [ADDR_WIDTH-1:0] r_prev_wr_addr;
  logic [ADDR_WIDTH-1:0] r_prev_rd_addr;
  logic                  r_prev_wr_vld;
  logic                  r_prev_rd_vld;
  logic                  r_addr_err;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_both_req;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_skip;
  logic                  w_rd_skip;
  logic                  w_do_write;
  logic                  w_do_read;
  logic [c_IDX_W-1:0]    w_wr_idx;
  logic [c_IDX_W-1:0]    w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Requests are masked during reset so ready stays low while reset is held.
  assign w_wr_req   = ~wr_en & reset;
  assign w_rd_req   = ~rd_en & reset;
  assign w_both_req = w_wr_req & w_rd_req;

  assign wr_ready = w_wr_req & (~w_rd_req | (r_last_grant == c_GNT_RD));
  assign rd_ready = w_rd_req & (~w_wr_req | (r_last_grant == c_GNT_WR));

  assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH);
  assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH);
  assign w_wr_idx      = wr_addr[c_IDX_W-1:0];
  assign w_rd_idx      = rd_addr[c_IDX_W-1:0];

  assign w_wr_skip = c_SKIP_EN & r_prev_wr_vld & (wr_addr == r_prev_wr_addr);
  assign w_rd_skip = c_SKIP_EN & r_prev_rd_vld & (rd_addr == r_prev_rd_addr);

  // Out-of-range reads are still performed, returning zero with a valid strobe.
  assign w_do_write = wr_ready & ~w_wr_skip & w_wr_in_range;
  assign w_do_read  = rd_ready & ~w_rd_skip;
  assign w_rd_word  = w_rd_in_range ? r_mem[w_rd_idx] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= c_GNT_RD;
    end else if (w_both_req) begin
      r_last_grant <= wr_ready ? c_GNT_WR : c_GNT_RD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_wr_addr <= '0;
      r_prev_rd_addr <= '0;
      r_prev_wr_vld  <= 1'b0;
      r_prev_rd_vld  <= 1'b0;
    end else begin
      if (c_SKIP_EN && wr_ready && !w_wr_skip) begin
        r_prev_wr_addr <= wr_addr;
        r_prev_wr_vld  <= 1'b1;
      end
      if (c_SKIP_EN && rd_ready && !w_rd_skip) begin
        r_prev_rd_addr <= rd_addr;
        r_prev_rd_vld  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= (wr_ready & ~w_wr_in_range) | (rd_ready & ~w_rd_in_range);
    end
  end

  // Storage carries no reset.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < c_NBYTES; b++) begin
        if (wr_be[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Each stage's data only loads behind a valid, so the last stage holds the
  // most recent read result between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe_vld <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_pipe_data[s] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_do_read;
      if (w_do_read) begin
        r_pipe_data[0] <= w_rd_word;
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        if (r_pipe_vld[s-1]) begin
          r_pipe_data[s] <= r_pipe_data[s-1];
        end
      end
    end
  end

  assign rd_data       = r_pipe_data[RD_LATENCY-1];
  assign rd_data_valid = r_pipe_vld[RD_LATENCY-1];
  assign addr_err      = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arb
// Description : Directed self-checking bench for data_mem_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arb;

  logic        clk;
  logic        rst_n;

  logic        a_wr_en, a_rd_en;
  logic [15:0] a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data;
  logic [3:0]  a_wr_be;
  logic        a_wr_ready, a_rd_ready, a_rd_data_valid, a_addr_err;
  logic [31:0] a_rd_data;

  logic        b_wr_en, b_rd_en;
  logic [15:0] b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data;
  logic [3:0]  b_wr_be;
  logic        b_wr_ready, b_rd_ready, b_rd_data_valid, b_addr_err;
  logic [31:0] b_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(16), .RD_LATENCY(2), .SKIP_REPEAT(0)
  ) u_dut_a (
    .clk(clk), .reset(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .wr_ready(a_wr_ready), .rd_ready(a_rd_ready),
    .rd_data(a_rd_data), .rd_data_valid(a_rd_data_valid), .addr_err(a_addr_err)
  );

  data_mem_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(16), .RD_LATENCY(1), .SKIP_REPEAT(1)
  ) u_dut_b (
    .clk(clk), .reset(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .wr_ready(b_wr_ready), .rd_ready(b_rd_ready),
    .rd_data(b_rd_data), .rd_data_valid(b_rd_data_valid), .addr_err(b_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1);
  end

  // Stimulus helpers: entered right after a falling edge, return right after one.
  task automatic wr_a(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_wr_en = 1'b0; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
    @(negedge clk);
    a_wr_en = 1'b1;
  endtask

  task automatic wr_b(input logic [15:0] addr, input logic [31:0] data);
    b_wr_en = 1'b0; b_wr_addr = addr; b_wr_data = data; b_wr_be = 4'hF;
    @(negedge clk);
    b_wr_en = 1'b1;
  endtask

  // Returns the data and the number of cycles from acceptance to the first strobe.
  task automatic rd_a(input logic [15:0] addr, output logic [31:0] d, output int lat);
    a_rd_en = 1'b0; a_rd_addr = addr;
    @(negedge clk);
    a_rd_en = 1'b1;
    lat = 0; d = '0;
    for (int n = 1; n <= 5; n++) begin
      if (a_rd_data_valid && lat == 0) begin lat = n; d = a_rd_data; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    #1;
    n_checks++; if (a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", a_wr_ready); end
    n_checks++; if (a_rd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready: got %b expected 0", a_rd_ready); end
    n_checks++; if (b_wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_wr_ready: got %b expected 0", b_wr_ready); end
    n_checks++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", a_rd_data); end
    n_checks++; if (a_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", a_rd_data_valid); end
    n_checks++; if (a_addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b expected 0", a_addr_err); end
    a_wr_en = 1'b1; a_rd_en = 1'b1; b_wr_en = 1'b1; b_rd_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    a_wr_en = 1'b0; a_wr_addr = 16'd5; a_wr_data = 32'hDEADBEEF; a_wr_be = 4'hF;
    #1;
    n_checks++; if (a_wr_ready !== 1'b1) begin n_fail++; $display("FAIL basic_wr_ready: got %b expected 1", a_wr_ready); end
    @(negedge clk);
    a_wr_en = 1'b1;
    a_rd_en = 1'b0; a_rd_addr = 16'd5;
    #1;
    n_checks++; if (a_rd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_rd_ready: got %b expected 1", a_rd_ready); end
    @(negedge clk);
    a_rd_en = 1'b1;
    #1;
    n_checks++; if (a_rd_ready !== 1'b0) begin n_fail++; $display("FAIL basic_rd_ready_drop: got %b expected 0", a_rd_ready); end
    n_checks++; if (a_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b expected 0", a_rd_data_valid); end
    @(negedge clk);
    n_checks++; if (a_rd_data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_at_lat: got %b expected 1", a_rd_data_valid); end
    n_checks++; if (a_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data: got %h expected deadbeef", a_rd_data); end
    @(negedge clk);
    n_checks++; if (a_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle: got %b expected 0", a_rd_data_valid); end
    n_checks++; if (a_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data_hold: got %h expected deadbeef", a_rd_data); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    int lat;
    wr_a(16'd3, 32'h11223344, 4'hF);
    wr_a(16'd3, 32'hAABBCCDD, 4'b0101);
    rd_a(16'd3, d, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL be_latency: got %0d expected 2", lat); end
    n_checks++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_merge: got %h expected 11bb33dd", d); end
    wr_a(16'd3, 32'hFFFFFFFF, 4'h0);
    rd_a(16'd3, d, lat);
    n_checks++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_zero: got %h expected 11bb33dd", d); end
  endtask

  task automatic test_arbitration();
    pulse_reset();
    a_wr_en = 1'b0; a_wr_addr = 16'd10; a_wr_data = 32'hCAFE0000; a_wr_be = 4'hF;
    a_rd_en = 1'b0; a_rd_addr = 16'd5;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if (a_wr_ready !== ((i % 2) == 0)) begin n_fail++; $display("FAIL arb_wr_grant[%0d]: got %b expected %b", i, a_wr_ready, (i % 2) == 0); end
      n_checks++; if (a_rd_ready !== ((i % 2) == 1)) begin n_fail++; $display("FAIL arb_rd_grant[%0d]: got %b expected %b", i, a_rd_ready, (i % 2) == 1); end
      n_checks++; if ((a_wr_ready & a_rd_ready) !== 1'b0) begin n_fail++; $display("FAIL arb_exclusive[%0d]: got both ready, expected at most one", i); end
      @(negedge clk);
    end
    a_wr_en = 1'b1; a_rd_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_addr_err();
    logic [31:0] d;
    int lat;
    wr_a(16'd4, 32'h44444444, 4'hF);
    a_rd_en = 1'b0; a_rd_addr = 16'd20;
    #1;
    n_checks++; if (a_rd_ready !== 1'b1) begin n_fail++; $display("FAIL oor_rd_ready: got %b expected 1", a_rd_ready); end
    @(negedge clk);
    a_rd_en = 1'b1;
    n_checks++; if (a_addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b expected 1", a_addr_err); end
    @(negedge clk);
    n_checks++; if (a_addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: got %b expected 0", a_addr_err); end
    n_checks++; if (a_rd_data_valid !== 1'b1) begin n_fail++; $display("FAIL oor_rd_valid: got %b expected 1", a_rd_data_valid); end
    n_checks++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h expected 0", a_rd_data); end
    wr_a(16'd20, 32'hFFFFFFFF, 4'hF);
    n_checks++; if (a_addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", a_addr_err); end
    @(negedge clk);
    rd_a(16'd4, d, lat);
    n_checks++; if (d !== 32'h44444444) begin n_fail++; $display("FAIL oor_wr_alias4: got %h expected 44444444", d); end
    rd_a(16'd5, d, lat);
    n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_wr_addr5: got %h expected deadbeef", d); end
  endtask

  task automatic test_skip_repeat();
    int strobes;
    wr_b(16'd7, 32'h00000077);
    wr_b(16'd8, 32'h00000088);
    wr_b(16'd8, 32'h00000099);
    strobes = 0;
    b_rd_en = 1'b0; b_rd_addr = 16'd7;
    #1;
    n_checks++; if (b_rd_ready !== 1'b1) begin n_fail++; $display("FAIL skip_ready0: got %b expected 1", b_rd_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (b_rd_ready !== 1'b1) begin n_fail++; $display("FAIL skip_ready1: got %b expected 1", b_rd_ready); end
    n_checks++; if (b_rd_data !== 32'h77) begin n_fail++; $display("FAIL skip_data7: got %h expected 00000077", b_rd_data); end
    if (b_rd_data_valid) strobes++;
    @(negedge clk);
    b_rd_addr = 16'd8;
    #1;
    n_checks++; if (b_rd_ready !== 1'b1) begin n_fail++; $display("FAIL skip_ready2: got %b expected 1", b_rd_ready); end
    n_checks++; if (b_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL skip_repeat_valid: got %b expected 0", b_rd_data_valid); end
    if (b_rd_data_valid) strobes++;
    @(negedge clk);
    b_rd_en = 1'b1;
    n_checks++; if (b_rd_data !== 32'h88) begin n_fail++; $display("FAIL skip_data8: got %h expected 00000088", b_rd_data); end
    if (b_rd_data_valid) strobes++;
    @(negedge clk);
    if (b_rd_data_valid) strobes++;
    n_checks++; if (strobes !== 2) begin n_fail++; $display("FAIL skip_strobes: got %0d expected 2", strobes); end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    a_rd_en = 1'b0; a_rd_addr = 16'd5;
    @(negedge clk);
    a_rd_en = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", a_rd_data_valid); end
    n_checks++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", a_rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (a_rd_data_valid !== 1'b0 || a_rd_data !== 32'h0) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_after_release: got %0d bad cycles expected 0", seen); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0; a_wr_be = '0;
    b_wr_en = 1'b1; b_rd_en = 1'b1; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0; b_wr_be = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_read();
    test_byte_enable();
    test_arbitration();
    test_addr_err();
    test_skip_repeat();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
